// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status ranges, serializer states and baud divisor helper
package midi_pkg;
    localparam logic [7:0] MIDI_CH_STATUS_LO  = 8'h80;
    localparam logic [7:0] MIDI_CH_STATUS_HI  = 8'hEF;
    localparam logic [7:0] MIDI_SYS_COMMON_LO = 8'hF0;
    localparam logic [7:0] MIDI_REALTIME_LO   = 8'hF8;

    typedef enum logic [2:0] {IDLE, CHECK, START, DATA, STOP} tx_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with exact occupancy, full/empty flags
module fifo_sync #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_i,
    input  logic [W-1:0]  data_i,
    input  logic          rd_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          push, pop;

    assign push    = wr_i & ~full_o;
    assign pop     = rd_i & ~empty_o;
    assign full_o  = cnt[AW];
    assign empty_o = cnt == '0;
    assign level_o = cnt;
    assign data_o  = mem[rp];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i)
        if (push) mem[wp] <= data_i;
endmodule

// File: rtl/midi_tx_serializer.sv
// midi_tx_serializer: buffered 8N1 MIDI transmitter with running-status suppression
module midi_tx_serializer
    import midi_pkg::*;
#(
    parameter int CLK_HZ  = 160_000_000,
    parameter int BAUD    = 31250,
    parameter int FIFO_AW = 4,
    parameter int RS_EN   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         data_i,
    input  logic               wr_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               busy_o,
    output logic               ovf_o,
    output logic               tx_o
);
    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    if (BAUD_DIV < 2) begin : g_baud_chk
        $error("BAUD_DIV must be at least 2");
    end

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [7:0]    sh, rs, head;
    logic [2:0]    bit_idx;
    logic          tick, pop, is_ch, is_sys, keep;

    fifo_sync #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_i   (wr_i),
        .data_i (data_i),
        .rd_i   (pop),
        .data_o (head),
        .full_o (full_o),
        .empty_o(empty_o),
        .level_o(level_o)
    );

    assign tick   = cnt == LAST;
    assign pop    = ~empty_o & (state == IDLE | (state == STOP & tick));
    assign is_ch  = sh >= MIDI_CH_STATUS_LO && sh <= MIDI_CH_STATUS_HI;
    assign is_sys = sh >= MIDI_SYS_COMMON_LO && sh < MIDI_REALTIME_LO;
    assign keep   = RS_EN == 0 || !(is_ch && sh == rs);
    assign busy_o = state != IDLE | ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            rs      <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b1;
            ovf_o   <= 1'b0;
        end else begin
            if (wr_i && full_o) ovf_o <= 1'b1;
            cnt <= (state inside {START, DATA, STOP} && !tick) ? cnt + CW'(1) : '0;
            case (state)
                IDLE: if (pop) begin
                    sh    <= head;
                    state <= CHECK;
                end
                CHECK: begin
                    bit_idx <= '0;
                    state   <= keep ? START : IDLE;
                    tx_o    <= !keep;
                    if (RS_EN != 0) rs <= is_ch ? sh : is_sys ? 8'h00 : rs;
                end
                START: if (tick) begin
                    state <= DATA;
                    tx_o  <= sh[0];
                end
                DATA: if (tick) begin
                    sh      <= sh >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    state   <= bit_idx == 3'd7 ? STOP : DATA;
                    tx_o    <= bit_idx == 3'd7 ? 1'b1 : sh[1];
                end
                STOP: if (tick) begin
                    // back-to-back frames go straight to CHECK, a one-cycle gap
                    if (pop) sh <= head;
                    state <= pop ? CHECK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
